// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter-side signal bundle for uart_tx_arbiter.
// Handshake: a byte moves on the rising edge where req_valid[i] && req_ready[i].
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [ID_W-1:0]      grant_id;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 busy;
    logic                 timeout_err;
    logic                 err_clr;
    logic [1:0]           state_dbg;

    modport slave (
        input  req_valid, req_data, tx_busy, tx_done, err_clr,
        output req_ready, grant_id, tx_start, tx_data, busy, timeout_err, state_dbg
    );

    modport master (
        output req_valid, req_data, tx_busy, tx_done, err_clr,
        input  req_ready, grant_id, tx_start, tx_data, busy, timeout_err, state_dbg
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers,
// with a start/busy/done sequencer and a sticky watchdog error.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             srst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_err_q, timeout_err_d;

    logic               sel_found;
    logic [ID_W-1:0]    sel_idx;
    logic [7:0]         sel_data;
    logic [NUM_REQ-1:0] ready;
    logic               accept;
    logic               in_xfer;
    logic               timeout_hit;
    logic [CNT_W-1:0]   cnt_inc;
    logic [ID_W-1:0]    ptr_next;

    // Rotating priority search starting at ptr; walking offsets downward leaves
    // the smallest matching offset as the final assignment.
    always_comb begin : p_select
        int              idx;
        logic [ID_W-1:0] idx_w;
        idx       = 0;
        idx_w     = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = ID_W'(idx);
            if (bus.req_valid[idx_w]) begin
                sel_found = 1'b1;
                sel_idx   = idx_w;
            end
        end
    end

    assign sel_data    = bus.req_data[{sel_idx, 3'b000} +: 8];
    assign accept      = |(ready & bus.req_valid);
    assign in_xfer     = (state_q == ST_START) || (state_q == ST_WAIT);
    assign timeout_hit = in_xfer && (cnt_q == CNT_LAST);
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign ptr_next    = (grant_q == ID_LAST) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // tx_done takes priority over the watchdog, which takes priority over tx_busy.
    always_comb begin : p_next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bus.tx_done || timeout_hit) begin
                    state_d = ST_IDLE;
                end else if (bus.tx_busy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.tx_done || timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin : p_datapath
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        tx_start_d    = tx_start_q;
        tx_data_d     = tx_data_q;
        cnt_d         = cnt_q;
        timeout_err_d = bus.err_clr ? 1'b0 : timeout_err_q;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                grant_d    = sel_idx;
                tx_data_d  = sel_data;
                tx_start_d = 1'b1;
                cnt_d      = '0;
            end
        end else if (in_xfer) begin
            cnt_d = cnt_inc;
            if (bus.tx_done) begin
                tx_start_d = 1'b0;
                ptr_d      = ptr_next;
            end else if (timeout_hit) begin
                tx_start_d    = 1'b0;
                ptr_d         = ptr_next;
                timeout_err_d = 1'b1;
            end else if (bus.tx_busy) begin
                tx_start_d = 1'b0;
            end
        end
    end

    // req_ready looks only at req_valid and registered state, never at tx_* inputs.
    always_comb begin : p_outputs
        ready = '0;
        if (srst_n && (state_q == ST_IDLE)) begin
            ready[sel_idx] = sel_found;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.grant_id    = grant_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.timeout_err = timeout_err_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: selection table plus hand-written
// transfer, fairness, timeout, fast-done and reset sequences.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TO_CYC  = 16;

    logic clk;
    logic srst_n;
    int   checks = 0;
    int   errors = 0;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk    (clk),
        .srst_n (srst_n),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All driving and checking happens 2 time units after a falling edge.
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        tick();
        srst_n      = 1'b0;
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        bus.err_clr = 1'b0;
        tick();
        tick();
        srst_n = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    logic [9:0] exp_q[$];
    logic       start_prev = 1'b0;

    always @(negedge clk) begin
        #3;
        if (bus.tx_start && !start_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_start", 32'd1, 32'd0);
            end else begin
                check("grant_and_data", {22'd0, bus.grant_id, bus.tx_data}, {22'd0, exp_q.pop_front()});
            end
        end
        start_prev = bus.tx_start;
    end

    // ---------------- producer model ----------------
    logic [7:0]         prod_q[NUM_REQ][$];
    logic               prod_en = 1'b0;
    logic [NUM_REQ-1:0] took    = '0;

    always @(negedge clk) begin
        logic [NUM_REQ-1:0]   v;
        logic [NUM_REQ*8-1:0] d;
        if (prod_en) begin
            v = '0;
            d = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (took[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
                if (prod_q[i].size() > 0) begin
                    v[i]         = 1'b1;
                    d[i*8 +: 8]  = prod_q[i][0];
                end
            end
            bus.req_valid = v;
            bus.req_data  = d;
            #1;
            took = bus.req_valid & bus.req_ready;
        end else begin
            took = '0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic direct_accept(input int id, input logic [7:0] data);
        tick();
        bus.req_valid             = NUM_REQ'(1 << id);
        bus.req_data[id*8 +: 8]   = data;
        exp_q.push_back({2'(id), data});
        tick();
        bus.req_valid = '0;
    endtask

    // Called in the first cycle tx_start is visible; plays the transmitter.
    task automatic serve(input int busy_dly, input int done_dly);
        repeat (busy_dly) tick();
        bus.tx_busy = 1'b1;
        tick();
        check("start_drop", {31'd0, bus.tx_start}, 32'd0);
        check("wait_state", {30'd0, bus.state_dbg}, 32'd2);
        check("ready_low_busy", {28'd0, bus.req_ready}, 32'd0);
        repeat (done_dly) tick();
        bus.tx_done = 1'b1;
        bus.tx_busy = 1'b0;
        tick();
        bus.tx_done = 1'b0;
        check("idle_after_done", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while (bus.tx_start !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("tx_start_seen", {31'd0, bus.tx_start}, 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int                 pre;
        logic [NUM_REQ-1:0] valid;
        logic [NUM_REQ-1:0] exp_ready;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{-1, 4'b0000, 4'b0000};
        vecs[1] = '{-1, 4'b1111, 4'b0001};
        vecs[2] = '{-1, 4'b1010, 4'b0010};
        vecs[3] = '{-1, 4'b1000, 4'b1000};
        vecs[4] = '{ 1, 4'b0011, 4'b0001};
        vecs[5] = '{-1, 4'b1111, 4'b0100};
        vecs[6] = '{ 3, 4'b0110, 4'b0010};
        vecs[7] = '{ 2, 4'b0111, 4'b0001};
        vecs[8] = '{-1, 4'b1001, 4'b1000};
        vecs[9] = '{ 0, 4'b0001, 4'b0001};

        srst_n        = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = '0;
        bus.tx_busy   = 1'b0;
        bus.tx_done   = 1'b0;
        bus.err_clr   = 1'b0;
        tick();
        check("rst_ready", {28'd0, bus.req_ready}, 32'd0);
        check("rst_outputs", {18'd0, bus.tx_start, bus.tx_data, bus.grant_id, bus.busy, bus.timeout_err, bus.state_dbg}, 32'd0);
        bus.req_valid = '0;
        srst_n        = 1'b1;

        // Selection table
        for (int k = 0; k < 10; k++) begin
            if (vecs[k].pre >= 0) begin
                direct_accept(vecs[k].pre, 8'h40 + 8'(vecs[k].pre));
                serve(0, 1);
            end
            tick();
            bus.req_valid = vecs[k].valid;
            #1;
            check($sformatf("select_vec%0d", k), {28'd0, bus.req_ready}, {28'd0, vecs[k].exp_ready});
            #1;
            bus.req_valid = '0;
        end

        // Single request from requester 1
        tick();
        bus.req_valid        = 4'b0010;
        bus.req_data[15:8]   = 8'hA5;
        exp_q.push_back({2'd1, 8'hA5});
        #1;
        check("single_ready", {28'd0, bus.req_ready}, 32'h2);
        tick();
        bus.req_valid = '0;
        check("single_start", {31'd0, bus.tx_start}, 32'd1);
        check("single_data", {24'd0, bus.tx_data}, 32'hA5);
        check("single_grant", {30'd0, bus.grant_id}, 32'd1);
        check("single_busy", {31'd0, bus.busy}, 32'd1);
        repeat (4) tick();
        check("start_held", {31'd0, bus.tx_start}, 32'd1);
        serve(1, 2);

        // Simultaneous after reset: 0 then 2
        do_reset();
        prod_q[0].push_back(8'h11);
        prod_q[2].push_back(8'h22);
        exp_q.push_back({2'd0, 8'h11});
        exp_q.push_back({2'd2, 8'h22});
        prod_en = 1'b1;
        repeat (2) begin
            wait_start(20);
            serve(2, 3);
        end
        check("simul_drained", exp_q.size(), 32'd0);

        // Fairness: everyone stays valid, grants rotate 0,1,2,3,0,1,2,3
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                prod_q[i].push_back(8'h10 + 8'(i));
                exp_q.push_back({2'(i), 8'h10 + 8'(i)});
            end
        end
        repeat (8) begin
            wait_start(20);
            serve(2, 3);
        end
        check("fair_drained", exp_q.size(), 32'd0);
        tick();
        prod_en       = 1'b0;
        tick();
        bus.req_valid = '0;

        // Watchdog on requester 3
        do_reset();
        direct_accept(3, 8'h3C);
        repeat (15) tick();
        check("no_early_timeout", {30'd0, bus.busy, bus.timeout_err}, 32'h2);
        tick();
        check("timeout_err", {31'd0, bus.timeout_err}, 32'd1);
        check("timeout_idle", {30'd0, bus.busy, bus.tx_start}, 32'd0);
        bus.req_valid = 4'b1001;
        bus.req_data  = {8'h33, 8'h00, 8'h00, 8'h0F};
        exp_q.push_back({2'd0, 8'h0F});
        #1;
        check("after_timeout_ready", {28'd0, bus.req_ready}, 32'h1);
        tick();
        bus.req_valid = '0;
        check("err_sticky", {31'd0, bus.timeout_err}, 32'd1);
        bus.err_clr = 1'b1;
        tick();
        check("err_clr", {31'd0, bus.timeout_err}, 32'd0);
        repeat (15) tick();
        check("set_beats_clr", {31'd0, bus.timeout_err}, 32'd1);
        tick();
        check("clr_after_set", {31'd0, bus.timeout_err}, 32'd0);
        bus.err_clr = 1'b0;

        // Fast done while still in START (ptr moves 1 -> 2)
        direct_accept(1, 8'h5A);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check("fast_done_idle", {29'd0, bus.busy, bus.tx_start, bus.timeout_err}, 32'd0);
        bus.req_valid = 4'b0110;
        #1;
        check("fast_done_ptr", {28'd0, bus.req_ready}, 32'h4);
        #1;
        bus.req_valid = '0;

        // Reset during WAIT_DONE with ptr at 3
        direct_accept(2, 8'h66);
        serve(0, 1);
        direct_accept(3, 8'h77);
        bus.tx_busy = 1'b1;
        tick();
        check("pre_reset_wait", {30'd0, bus.state_dbg}, 32'd2);
        bus.req_valid        = 4'b1100;
        bus.req_data[23:16]  = 8'h99;
        bus.req_data[31:24]  = 8'h88;
        #1;
        srst_n = 1'b0;
        #1;
        check("midrst_outputs", {18'd0, bus.tx_start, bus.tx_data, bus.grant_id, bus.busy, bus.timeout_err, bus.state_dbg}, 32'd0);
        check("midrst_ready", {28'd0, bus.req_ready}, 32'd0);
        bus.tx_busy = 1'b0;
        tick();
        srst_n = 1'b1;
        exp_q.push_back({2'd2, 8'h99});
        #1;
        check("post_rst_ready", {28'd0, bus.req_ready}, 32'h4);
        tick();
        bus.req_valid = '0;
        check("post_rst_grant", {22'd0, bus.grant_id, bus.tx_data}, {22'd0, 2'd2, 8'h99});
        serve(1, 1);
        tick();
        check("final_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global guard so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among `NUM_REQ` byte producers. It accepts one byte at a time from the selected requester and drives the transmitter's start/data inputs. It tracks the transmitter's busy/done handshake and applies a watchdog timeout. It sits between the system-side producers and the UART top-level transmit path.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `TIMEOUT_CYCLES`, default 4096: clk cycles allowed from `tx_start` rise to `tx_done`.
- `clk`  in  1: system clock; all logic on rising edge.
- `srst_n`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  NUM_REQ: per-requester byte-valid.
- `req_data`  in  NUM_REQ*8: requester i's byte on bits [8i+7:8i].
- `req_ready`  out  NUM_REQ: combinational accept; the transfer occurs on the edge where `req_valid[i]` and `req_ready[i]` are both high.
- `grant_id`  out  clog2(NUM_REQ): index of the requester owning the current transfer.
- `tx_start`  out  1: registered start request to the transmitter.
- `tx_data`  out  8: registered byte to the transmitter; stable from accept until return to IDLE.
- `tx_busy`  in  1: transmitter has taken the start and is shifting.
- `tx_done`  in  1: one-cycle pulse at transmitter stop-bit end.
- `busy`  out  1: high whenever state ≠ IDLE.
- `timeout_err`  out  1: sticky watchdog flag.
- `err_clr`  in  1: synchronous clear of `timeout_err`.

## Operation
- The FSM has three states: IDLE, START, WAIT_DONE.
- **Reset:** state IDLE; `tx_start`, `tx_data`, `grant_id`, `timeout_err`, and the timeout counter are 0; `busy`=0; round-robin pointer `ptr`=0. `req_ready` is 0 while `srst_n` is low.
- **IDLE:**
  - Selected index g is the first i with `req_valid[i]`=1, searching ptr, ptr+1, … NUM_REQ-1, 0, … with wrap.
  - `req_ready` is one-hot at g and zero for all others. `req_ready` is all-zero when no request is valid or when state ≠ IDLE.
  - On the accept edge: `tx_data`←`req_data[g]`, `grant_id`←g, `tx_start`←1, counter←0, state←START.
- **START:**
  - `tx_start` holds 1 until `tx_busy`=1 is sampled. The transmitter's baud tick is slower than clk, so a one-cycle pulse is insufficient.
  - On `tx_busy`=1: `tx_start`←0, state←WAIT_DONE.
- **WAIT_DONE:** on `tx_done`=1, state←IDLE and `ptr`←(grant_id+1) mod NUM_REQ.
- **tx_done during START** (fast transmitter): treated as completion; `tx_start`←0, state←IDLE, `ptr` advances.
- **Watchdog:**
  - The counter increments every cycle in START and WAIT_DONE, saturating at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES-1 without `tx_done`: `timeout_err`←1, `tx_start`←0, state←IDLE, and `ptr` advances. The stuck requester is therefore not re-favoured.
  - `tx_done` and the timeout on the same edge: `tx_done` wins and no error is set.
- **err_clr:** clears `timeout_err` on the next edge. If a timeout fires on the same edge, the set wins.
- **Reset mid-transfer:** the asynchronous assert returns every register to its reset value immediately. The accepted byte is dropped; requesters must not assume delivery.
- Widths: `ptr` and `grant_id` are clog2(NUM_REQ) bits. The modulo wrap is explicit, so NUM_REQ need not be a power of two. The counter is clog2(TIMEOUT_CYCLES+1) bits.

## Timing
- Accept edge → `tx_start`=1 and `busy`=1 in the following cycle (1-cycle latency).
- `tx_start` deasserts in the cycle after `tx_busy` is first sampled high.
- `tx_done` edge → IDLE in the next cycle. `req_ready` can assert in that same cycle, so the minimum gap between accepts is 1 IDLE cycle.
- `req_ready` depends combinationally on `req_valid` and registered state only. There is no path from `tx_*` inputs to `req_ready`.
- `tx_data` and `grant_id` change only on accept edges.

## Test plan
- **Single request:** requester 1 presents 0xA5 → `req_ready[1]` asserts in 1 cycle. The next cycle shows `tx_start`=1, `tx_data`=0xA5, `grant_id`=1. A bench model raises `tx_busy` 5 cycles later → `tx_start` drops the next cycle. `tx_done` → `busy`=0.
- **Simultaneous after reset:** requesters 0 and 2 both valid → bytes are sent in order 0 then 2.
- **Fairness:** all 4 requesters continuously valid with distinct bytes 0x10..0x13, ptr=0 → grant sequence 0,1,2,3,0,1; no requester is granted twice in a row.
- **Timeout:** TIMEOUT_CYCLES=16, `tx_busy` and `tx_done` held 0 after requester 3 is accepted → `timeout_err`=1 and state IDLE 16 cycles after `tx_start` rise. The next grant goes to requester 0. `err_clr` clears the flag.
- **Fast done:** `tx_done` pulses while still in START (`tx_busy` never high) → returns to IDLE, `timeout_err` stays 0.
- **Reset mid-transfer:** `srst_n` pulled low during WAIT_DONE, between clock edges → all outputs 0 immediately. After release, a pending requester 2 is granted with ptr=0 ordering.
